// File: rtl/id_compare_sequencer.sv
// rtl/id_compare_sequencer.sv - CAN bit front end and sequencer for the identifier comparator
// Build option: define IDSEQ_MAJORITY_VOTE_EN to take each bit value as the 2-of-3 majority
// of the three sample instants instead of the third sample alone.
module id_compare_sequencer #(
   parameter int BIT_CYCLES = 100,
   parameter int SAMPLE_POS = 60,
   parameter int SAMPLE_GAP = 2,
   parameter int IDLE_BITS  = 11,
   parameter int ID_BITS    = 12,
   parameter int WAIT_BITS  = 2
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        canRx,
   input  logic        cmpDone,
   input  logic        cmpMatch,
   output logic        cmpResetN,
   output logic        cmpEnable,
   output logic        cmpData,
   output logic        cmpSamplePulse,
   output logic        busIdle,
   output logic        frameMatch,
   output logic        frameMiss,
   output logic        stuffError,
   output logic [15:0] matchCount,
   output logic [2:0]  state
);
   localparam int TW          = $clog2(BIT_CYCLES);
   localparam int IW          = $clog2(IDLE_BITS + 1);
   localparam int BW          = $clog2(ID_BITS + 1);
   localparam int WAIT_CYCLES = WAIT_BITS * BIT_CYCLES;
   localparam int WW          = $clog2(WAIT_CYCLES);

   localparam logic [TW-1:0] T_S1   = TW'(SAMPLE_POS);
   localparam logic [TW-1:0] T_S2   = TW'(SAMPLE_POS + SAMPLE_GAP);
   localparam logic [TW-1:0] T_S3   = TW'(SAMPLE_POS + 2 * SAMPLE_GAP);
   localparam logic [TW-1:0] T_LAST = TW'(BIT_CYCLES - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(ID_BITS - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_BUSWAIT = 3'd0,
      S_IDLE    = 3'd1,
      S_STREAM  = 3'd2,
      S_WAIT    = 3'd3
   } state_t;

   state_t        state_q, state_d;
   logic          rx_meta_q, rx_meta_d;
   logic          rx_s_q, rx_s_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]    run_q, run_d;
   logic          last_q, last_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [15:0]   match_cnt_q, match_cnt_d;

   logic at_s1, at_s2, at_s3, bit_val, stuff_bit;

   assign at_s1     = (timer_q == T_S1);
   assign at_s2     = (timer_q == T_S2);
   assign at_s3     = (timer_q == T_S3);
   // Five equal bits in a row means the next bit on the wire is a stuff bit.
   assign stuff_bit = (run_q == 3'd5);

`ifdef IDSEQ_MAJORITY_VOTE_EN
   logic s1_q, s1_d, s2_q, s2_d;

   // Capture rxS at the first two sample instants for the majority vote.
   always_comb begin
      s1_d = s1_q;
      s2_d = s2_q;
      if (at_s1) s1_d = rx_s_q;
      if (at_s2) s2_d = rx_s_q;
   end

   // Sample holding registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign bit_val = (s1_q & s2_q) | (s1_q & rx_s_q) | (s2_q & rx_s_q);
`else
   assign bit_val = rx_s_q;
`endif

   assign cmpData    = rx_s_q;
   assign matchCount = match_cnt_q;
   assign state      = state_q;

   // Next-state, bit timing, destuffing and per-frame reporting.
   always_comb begin
      rx_meta_d      = canRx;
      rx_s_d         = rx_meta_q;
      timer_d        = (timer_q == T_LAST) ? '0 : timer_q + 1'b1;
      state_d        = state_q;
      idle_d         = idle_q;
      bit_cnt_d      = bit_cnt_q;
      run_d          = run_q;
      last_d         = last_q;
      wait_d         = wait_q;
      match_cnt_d    = match_cnt_q;
      cmpResetN      = 1'b0;
      cmpEnable      = 1'b0;
      cmpSamplePulse = 1'b0;
      busIdle        = 1'b0;
      frameMatch     = 1'b0;
      frameMiss      = 1'b0;
      stuffError     = 1'b0;
      case (state_q)
         S_BUSWAIT: begin
            if (at_s3) begin
               if (!bit_val) begin
                  idle_d = '0;
               end else if (idle_q == IDLE_LAST) begin
                  idle_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
         end
         S_IDLE: begin
            busIdle = 1'b1;
            // SOF: rxS is about to fall, so the timer restarts on that same edge.
            if (rx_s_q && !rx_meta_q) begin
               timer_d   = '0;
               bit_cnt_d = '0;
               run_d     = 3'd0;
               state_d   = S_STREAM;
            end
         end
         S_STREAM: begin
            cmpResetN = 1'b1;
            cmpEnable = 1'b1;
            if (!stuff_bit && (at_s1 || at_s2 || at_s3)) cmpSamplePulse = 1'b1;
            if (at_s3) begin
               if (stuff_bit) begin
                  if (bit_val == last_q) begin
                     stuffError = 1'b1;
                     state_d    = S_BUSWAIT;
                  end else begin
                     run_d  = 3'd1;
                     last_d = bit_val;
                  end
               end else begin
                  run_d     = (run_q != 3'd0 && bit_val == last_q) ? run_q + 3'd1 : 3'd1;
                  last_d    = bit_val;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == BIT_LAST) begin
                     wait_d  = '0;
                     state_d = S_WAIT;
                  end
               end
            end
         end
         S_WAIT: begin
            cmpResetN = 1'b1;
            // The comparator's answer takes priority over a coincident timeout.
            if (cmpDone) begin
               state_d = S_BUSWAIT;
               if (cmpMatch) begin
                  frameMatch = 1'b1;
                  if (match_cnt_q != 16'hFFFF) match_cnt_d = match_cnt_q + 16'd1;
               end else begin
                  frameMiss = 1'b1;
               end
            end else if (wait_q == WAIT_LAST) begin
               stuffError = 1'b1;
               state_d    = S_BUSWAIT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = S_BUSWAIT;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= S_BUSWAIT;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         timer_q     <= '0;
         idle_q      <= '0;
         bit_cnt_q   <= '0;
         run_q       <= 3'd0;
         last_q      <= 1'b1;
         wait_q      <= '0;
         match_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         timer_q     <= timer_d;
         idle_q      <= idle_d;
         bit_cnt_q   <= bit_cnt_d;
         run_q       <= run_d;
         last_q      <= last_d;
         wait_q      <= wait_d;
         match_cnt_q <= match_cnt_d;
      end
   end

endmodule
